// File: rtl/vm_coin_front.sv
// vm_coin_front
//   Coin front-end for the vending machine FSM. Synchronises the raw Rs.5 / Rs.10
//   sensors, turns each coin into a single event, queues events in a small FIFO and
//   replays them one per slot on in_mny. Also keeps a saturating credit total and
//   pulses coin_reject for coins that cannot be queued.
//
//   Optional build macro COIN_DEBOUNCE_EN: a synced sensor must read high for
//   DEB_CYCLES consecutive cycles before its event fires.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   coin5_raw   Rs.5 sensor (asynchronous, high while coin present)
//   coin10_raw  Rs.10 sensor (asynchronous, high while coin present)
//   txn_clr     sync pulse: flush FIFO, zero credit, return FSM to idle
//   in_mny      00 none, 01 Rs.5, 10 Rs.10 (registered)
//   coin_reject 1-cycle pulse when a detected coin is not accepted
//   credit      Rs accepted since reset / txn_clr, saturating
//   fifo_cnt    occupied FIFO entries
//   busy        FIFO non-empty or FSM not idle
module vm_coin_front #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned CREDIT_W   = 6,
  parameter int unsigned DEB_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    coin5_raw,
  input  logic                    coin10_raw,
  input  logic                    txn_clr,
  output logic [1:0]              in_mny,
  output logic                    coin_reject,
  output logic [CREDIT_W-1:0]     credit,
  output logic [$clog2(DEPTH):0]  fifo_cnt,
  output logic                    busy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
  localparam logic [1:0] CODE5  = 2'b01;
  localparam logic [1:0] CODE10 = 2'b10;
  localparam logic [CREDIT_W+4:0] CMAX = {5'b0, {CREDIT_W{1'b1}}};

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || GAP_CYCLES < 1 || DEB_CYCLES < 1)
  begin : g_bad_param
    $error("vm_coin_front: illegal parameter value");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_GAP} state_t;

  // ---------------- input path ----------------
  logic [1:0] sync5, sync10;
  logic       ev5, ev10;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync5  <= '0;
      sync10 <= '0;
    end else begin
      sync5  <= {sync5[0], coin5_raw};
      sync10 <= {sync10[0], coin10_raw};
    end
  end

`ifdef COIN_DEBOUNCE_EN
  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
  logic [DW-1:0] deb5, deb10;

  // Counter saturates at DEB_CYCLES so a held sensor fires exactly once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb5  <= '0;
      deb10 <= '0;
    end else begin
      if (!sync5[1])                    deb5 <= '0;
      else if (deb5 != DW'(DEB_CYCLES)) deb5 <= deb5 + DW'(1);
      if (!sync10[1])                    deb10 <= '0;
      else if (deb10 != DW'(DEB_CYCLES)) deb10 <= deb10 + DW'(1);
    end
  end

  assign ev5  = sync5[1]  && (deb5  == DW'(DEB_CYCLES - 1));
  assign ev10 = sync10[1] && (deb10 == DW'(DEB_CYCLES - 1));
`else
  logic dly5, dly10;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dly5  <= 1'b0;
      dly10 <= 1'b0;
    end else begin
      dly5  <= sync5[1];
      dly10 <= sync10[1];
    end
  end

  assign ev5  = sync5[1]  & ~dly5;
  assign ev10 = sync10[1] & ~dly10;
`endif

  // ---------------- FIFO and acceptance ----------------
  logic [1:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   free, n_push;
  logic          acc5, acc10, pop;

  // Free space is taken before any pop this cycle: a pop does not make room
  // for a same-cycle push.
  assign free   = (PW+1)'(DEPTH) - fifo_cnt;
  assign acc10  = ev10 && !txn_clr && (free != '0);
  assign acc5   = ev5  && !txn_clr && (acc10 ? (free >= (PW+1)'(2)) : (free != '0));
  assign n_push = (PW+1)'(acc10) + (PW+1)'(acc5);

  // Rs.10 occupies the older slot when both coins arrive together.
  always_ff @(posedge clk) begin
    if (acc10) mem[wr_ptr] <= CODE10;
    if (acc5)  mem[acc10 ? wr_ptr + PW'(1) : wr_ptr] <= CODE5;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (txn_clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      wr_ptr   <= wr_ptr + n_push[PW-1:0];
      rd_ptr   <= rd_ptr + PW'(pop);
      fifo_cnt <= fifo_cnt + n_push - (PW+1)'(pop);
    end
  end

  // ---------------- credit and reject ----------------
  logic [4:0]          add;
  logic [CREDIT_W+4:0] credit_sum;

  assign add        = (acc10 ? 5'd10 : 5'd0) + (acc5 ? 5'd5 : 5'd0);
  assign credit_sum = {5'b0, credit} + {{CREDIT_W{1'b0}}, add};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit      <= '0;
      coin_reject <= 1'b0;
    end else begin
      coin_reject <= (ev5 & ~acc5) | (ev10 & ~acc10);
      if (txn_clr)               credit <= '0;
      else if (credit_sum > CMAX) credit <= '1;
      else                       credit <= credit_sum[CREDIT_W-1:0];
    end
  end

  // ---------------- replay FSM ----------------
  state_t        state, state_nxt;
  logic [GW-1:0] gap_cnt, gap_nxt;
  logic [1:0]    in_mny_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      gap_cnt <= '0;
      in_mny  <= 2'b00;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_nxt;
      in_mny  <= in_mny_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    gap_nxt    = gap_cnt;
    in_mny_nxt = 2'b00;
    pop        = 1'b0;
    if (txn_clr) begin
      state_nxt = ST_IDLE;
      gap_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_cnt != '0) begin
            pop        = 1'b1;
            in_mny_nxt = mem[rd_ptr];
            state_nxt  = ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          state_nxt = ST_GAP;
          gap_nxt   = GW'(GAP_CYCLES - 1);
        end
        ST_GAP: begin
          if (gap_cnt == '0) state_nxt = ST_IDLE;
          else               gap_nxt   = gap_cnt - GW'(1);
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign busy = (fifo_cnt != '0) || (state != ST_IDLE);

endmodule
